// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      LOAD
   } state_e;

   localparam int                   DIGIT_W       = 4;
   localparam logic [DIGIT_W-1:0]   ADD3_THRESH   = 4'd5;
   localparam logic [DIGIT_W-1:0]   BCD_MAX_DIGIT = 4'd9;

   // Largest value that fits in the given number of decimal digits.
   function automatic longint unsigned max_value(input int unsigned digits);
      longint unsigned v;
      v = 1;
      for (int unsigned i = 0; i < digits; i++) begin
         v = v * 10;
      end
      return v - 1;
   endfunction

endpackage

// File: rtl/bin_to_bcd_seq_add3.sv
// Double-dabble digit correction: add 3 to a BCD digit of 5 or more before shifting.
module bcd_add3
   import bcd_pkg::*;
(
   input  logic [DIGIT_W-1:0] in_i,
   output logic [DIGIT_W-1:0] out_o
);

   assign out_o = (in_i >= ADD3_THRESH) ? in_i + 4'd3 : in_i;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-and-add-3 binary to BCD converter with start/busy/done handshake.
// state | meaning
// IDLE  | waiting for start; result registers hold last conversion
// SHIFT | one add-3/shift step per edge, WIDTH steps total
// LOAD  | check overflow, publish digits, pulse done
module bin_to_bcd_seq
   import bcd_pkg::*;
#(
   parameter int WIDTH  = 14,
   parameter int DIGITS = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] bin,
   output logic             busy,
   output logic             done,
   output logic             ovf,
   output logic [3:0]       bcd0,
   output logic [3:0]       bcd1,
   output logic [3:0]       bcd2,
   output logic [3:0]       bcd3
);

   localparam int SW = (DIGITS + 1) * DIGIT_W;
   localparam int CW = $clog2(WIDTH + 1);

   state_e                        state_q, state_d;
   logic [WIDTH-1:0]              shift_q, shift_d;
   logic [SW-1:0]                 scr_q, scr_d, scr_adj;
   logic [CW-1:0]                 cnt_q, cnt_d;
   logic                          busy_q, busy_d;
   logic                          done_q, done_d;
   logic                          ovf_q, ovf_d;
   logic [3:0][DIGIT_W-1:0]       bcd_q, bcd_d;
   logic                          of;

   for (genvar g = 0; g < DIGITS + 1; g++) begin : g_add3
      bcd_add3 u_add3 (
         .in_i  (scr_q[g*DIGIT_W +: DIGIT_W]),
         .out_o (scr_adj[g*DIGIT_W +: DIGIT_W])
      );
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         shift_q <= '0;
         scr_q   <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         ovf_q   <= 1'b0;
         bcd_q   <= '0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         scr_q   <= scr_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         ovf_q   <= ovf_d;
         bcd_q   <= bcd_d;
      end
   end

   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      scr_d   = scr_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      ovf_d   = ovf_q;
      bcd_d   = bcd_q;
      of      = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               shift_d = bin;
               scr_d   = '0;
               cnt_d   = CW'(WIDTH);
               busy_d  = 1'b1;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            {scr_d, shift_d} = {scr_adj, shift_q} << 1;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CW'(1)) begin
               state_d = LOAD;
            end
         end
         LOAD: begin
            // Extra top digit nonzero means the value exceeds the DIGITS range.
            of = (scr_q[SW-1 -: DIGIT_W] != '0);
            for (int i = 0; i < DIGITS; i++) begin
               if (scr_q[i*DIGIT_W +: DIGIT_W] > BCD_MAX_DIGIT) begin
                  of = 1'b1;
               end
            end
            ovf_d = of;
            for (int i = 0; i < 4; i++) begin
               if (of) begin
                  bcd_d[i] = BCD_MAX_DIGIT;
               end else if (i < DIGITS) begin
                  bcd_d[i] = scr_q[i*DIGIT_W +: DIGIT_W];
               end else begin
                  bcd_d[i] = '0;
               end
            end
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign busy = busy_q;
   assign done = done_q;
   assign ovf  = ovf_q;
   assign bcd0 = bcd_q[0];
   assign bcd1 = bcd_q[1];
   assign bcd2 = bcd_q[2];
   assign bcd3 = bcd_q[3];

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Bench for bin_to_bcd_seq: arithmetic reference model checked every cycle plus directed literal checks.
module tb_bin_to_bcd_seq;

   localparam int WIDTH = 14;
   localparam int LAT   = WIDTH + 1;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [WIDTH-1:0] bin;
   logic             busy, done, ovf;
   logic [3:0]       bcd0, bcd1, bcd2, bcd3;

   int pass_cnt  = 0;
   int total_cnt = 0;
   bit chk_en    = 0;

   bin_to_bcd_seq #(.WIDTH(WIDTH), .DIGITS(4)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .bin   (bin),
      .busy  (busy),
      .done  (done),
      .ovf   (ovf),
      .bcd0  (bcd0),
      .bcd1  (bcd1),
      .bcd2  (bcd2),
      .bcd3  (bcd3)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] exp_bcd(input int v);
      if (v > 9999) return 16'h9999;
      return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      total_cnt++;
      if (act == exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Reference model: a conversion accepted when idle completes LAT edges later.
   logic        m_busy, m_done, m_ovf;
   logic [15:0] m_bcd;
   int          m_rem, m_val;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_busy = 0; m_done = 0; m_ovf = 0; m_bcd = '0; m_rem = 0; m_val = 0;
      end else begin
         m_done = 0;
         if (!m_busy) begin
            if (start) begin
               m_busy = 1;
               m_rem  = LAT;
               m_val  = int'(bin);
            end
         end else begin
            m_rem--;
            if (m_rem == 0) begin
               m_busy = 0;
               m_done = 1;
               m_ovf  = (m_val > 9999);
               m_bcd  = exp_bcd(m_val);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en && !rst) begin
         chk("busy", int'(busy), int'(m_busy));
         chk("done", int'(done), int'(m_done));
         chk("ovf", int'(ovf), int'(m_ovf));
         chk("bcd", int'({bcd3, bcd2, bcd1, bcd0}), int'(m_bcd));
      end
   end

   task automatic wait_done(output int cyc, output int busy_n);
      cyc = 0;
      busy_n = 0;
      do begin
         @(negedge clk);
         cyc++;
         if (busy) busy_n++;
      end while (!done && cyc < 40);
      if (!done) chk("done_timeout", 0, 1);
   endtask

   task automatic conv(input int v, input int exp_ovf, input logic [15:0] exp_d);
      int cyc, bn;
      @(negedge clk);
      bin   = WIDTH'(v);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 1;
      bn  = busy ? 1 : 0;
      while (!done && cyc < 40) begin
         @(negedge clk);
         cyc++;
         if (busy) bn++;
      end
      if (!done) chk("done_timeout", 0, 1);
      chk($sformatf("latency_%0d", v), cyc - 1, LAT);
      chk($sformatf("busy_cycles_%0d", v), bn, LAT);
      chk($sformatf("lit_bcd_%0d", v), int'({bcd3, bcd2, bcd1, bcd0}), int'(exp_d));
      chk($sformatf("lit_ovf_%0d", v), int'(ovf), exp_ovf);
   endtask

   initial begin
      int cyc, bn, nd, k, last;
      rst = 1'b1; start = 1'b0; bin = '0;
      repeat (3) @(negedge clk);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_out", int'({ovf, bcd3, bcd2, bcd1, bcd0}), 0);
      rst = 1'b0;
      chk_en = 1;

      conv(0, 0, 16'h0000);
      conv(1234, 0, 16'h1234);
      conv(9999, 0, 16'h9999);
      conv(5, 0, 16'h0005);
      conv(10000, 1, 16'h9999);
      conv(16383, 1, 16'h9999);
      conv(42, 0, 16'h0042);

      // Start during a busy conversion must be ignored.
      @(negedge clk);
      bin = WIDTH'(777); start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      bin = WIDTH'(3333); start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(cyc, bn);
      chk("ignored_start_bcd", int'({bcd3, bcd2, bcd1, bcd0}), 16'h0777);
      nd = 0;
      repeat (25) begin
         @(negedge clk);
         if (done) nd++;
      end
      chk("ignored_start_extra_done", nd, 0);

      // Asynchronous reset in the middle of a conversion.
      @(negedge clk);
      bin = WIDTH'(4321); start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_busy", int'(busy), 0);
      chk("async_rst_done", int'(done), 0);
      chk("async_rst_out", int'({ovf, bcd3, bcd2, bcd1, bcd0}), 0);
      @(negedge clk);
      rst = 1'b0;
      nd = 0;
      repeat (30) begin
         @(negedge clk);
         if (done) nd++;
      end
      chk("after_rst_no_done", nd, 0);
      conv(2468, 0, 16'h2468);

      // Back-to-back conversions with start held high.
      @(negedge clk);
      bin = '0; start = 1'b1;
      k = 0; last = 0; cyc = 0;
      while (k <= 20 && cyc < 600) begin
         @(negedge clk);
         cyc++;
         if (done) begin
            chk($sformatf("b2b_bcd_%0d", k), int'({bcd3, bcd2, bcd1, bcd0}),
                int'({8'h00, 4'(k / 10), 4'(k % 10)}));
            if (k > 0) chk($sformatf("b2b_spacing_%0d", k), cyc - last, WIDTH + 2);
            last = cyc;
            k++;
            if (k <= 20) bin = WIDTH'(k);
            else start = 1'b0;
         end
      end
      if (k <= 20) chk("b2b_timeout", k, 21);
      repeat (3) @(negedge clk);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
